addroundkey_round_ctrl: RTL and testbench
=========================================

# addroundkey_round_ctrl

Sequential AddRoundKey stage and round controller for the AES-128 encryption datapath. It sits directly downstream of `mixcolumn` and closes the round loop. It holds the 128-bit round-state register and XORs each round's input with a round key taken from a valid/ready key stream. Its registered state drives the SubBytes → ShiftRows → MixColumns combinational chain, which produces the next round's input.

## Interface

Parameters:
- `NR`, default 10: number of cipher rounds, i.e. the number of round keys consumed after round key 0.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a new block; sampled only in IDLE.
- `pt_data` in [0:127]: plaintext; captured on the accepted `start`.
- `mc_data` in [0:127]: `mixcolumn` output `C_data` of the current state; used as the source for rounds 1..NR-1.
- `sr_data` in [0:127]: ShiftRows output of the current state; used as the source for final round NR (MixColumns bypass).
- `rk_data` in [0:127]: round key, in byte order identical to the state.
- `rk_valid` in 1: the key stream has a key available.
- `rk_ready` out 1: the block accepts a key this cycle.
- `state_q` out [0:127]: registered round state; feeds SubBytes.
- `round_q` out 4: index of the last round key applied.
- `busy` out 1: high in LOAD and ROUND.
- `done` out 1: single-cycle pulse; `state_q` holds the ciphertext.

Byte order: byte k = bits [8k:8k+7]. Column c = bytes 4c..4c+3, which matches the `mixcolumn` column grouping.

## Operation

FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE: `rk_ready`=0. On `start`=1, capture `pt_data` into `pt_q`, set `round_q`=0 and go to LOAD.
- LOAD: `rk_ready`=1. On key handshake (`rk_valid`&&`rk_ready`): `state_q` ← `pt_q` ^ `rk_data`, `round_q` stays 0, go to ROUND.
- ROUND: `rk_ready`=1. On each handshake, `round_q` ← `round_q`+1.
  - If the new round < NR: `state_q` ← `mc_data` ^ `rk_data`.
  - If the new round = NR: `state_q` ← `sr_data` ^ `rk_data`, then go to DONE.
- DONE: `done`=1 for exactly this one cycle; `rk_ready`=0. Go to IDLE unconditionally. A `start` here is ignored.
- With no handshake, `state_q` and `round_q` hold.
- `start` outside IDLE is ignored and has no side effects.
- Exactly NR+1 keys are consumed per block, never more. The key source must not see `rk_ready` outside LOAD/ROUND.
- `state_q` holds the ciphertext from DONE until the next LOAD handshake.
- XOR is a bitwise 128-bit operation with no width growth. `round_q` never exceeds NR, and NR ≤ 15.

## Timing

- Reset values (`rst_n`=0 at an edge): state IDLE, `state_q`=0, `pt_q`=0, `round_q`=0, `rk_ready`=0, `busy`=0, `done`=0.
- Reset asserted mid-block aborts the block in the same edge. No `done` is produced, and keys in flight are dropped without handshake.
- Outputs are registered or decoded from FSM state only; `rk_ready` has no combinational path from `rk_valid`.
- `mc_data` and `sr_data` must be settled combinational functions of `state_q` within the same cycle.
- Minimum latency with `rk_valid` held high:
  - `start` accepted at edge 0;
  - round-0 key at edge 1;
  - final key at edge NR+1;
  - `done` high in the cycle following edge NR+1.
  - For NR=10 that is 13 cycles from `start` to the end of `done`; the earliest next `start` is accepted one cycle after `done`.
- Stalls: each cycle with `rk_valid`=0 in LOAD/ROUND adds exactly one cycle of latency.

## Structure

- Shared package `aes_pkg`: FSM state typedef (IDLE/LOAD/ROUND/DONE), `AES_NR_128`=10, `AES_BLK_W`=128.
- One sub-module, `round_key_xor`: a combinational 3:1 source select (pt/mc/sr) followed by the 128-bit XOR with `rk_data`. It keeps the FSM module free of datapath.
- SubBytes, ShiftRows and `mixcolumn` stay outside this block. The bench instantiates them around it.

## Test plan

- FIPS-197 App. B test vector:
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, round keys streamed with no stalls.
  - Required: after the LOAD handshake `state_q`=193de3bea0f4e22b9ac68d2ae9f84808; `done` 13 cycles after `start`; `state_q`=3925841d02dc09fbdc118597196a0b32; exactly 11 handshakes.
- Same vector with `rk_valid` randomly low 50% of the time → identical ciphertext, latency = 13 + stall cycles, `state_q`/`round_q` stable during stalls.
- `start` pulsed in ROUND (round 4) and again in the DONE cycle → both ignored, ciphertext unchanged, no extra key handshakes.
- `rst_n` low for one cycle at round 6 → next cycle every output is at its reset value and no `done` fires; a following block with the App. B vector completes correctly.
- Back-to-back blocks: two plaintexts, second `start` in the first IDLE cycle after `done` → two correct ciphertexts, 22 handshakes total, `round_q` restarts at 0.
- `rk_ready` observed against FSM state → high only in LOAD/ROUND, including during and just after reset.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 datapath types: round-loop FSM states, source selects, block widths.
package aes_pkg;
  localparam int AES_NR_128 = 10;
  localparam int AES_BLK_W  = 128;
  localparam int NUM_LANES  = 16;
  localparam int VEC_W      = AES_BLK_W / NUM_LANES;

  typedef logic [0:AES_BLK_W-1] aes_blk_t;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} ark_state_e;
  typedef enum logic [1:0] {SRC_PT, SRC_MC, SRC_SR} ark_src_e;
endpackage

// File: rtl/addroundkey_round_ctrl_if.sv
// Round-key stream handshake between the key scheduler (master) and the AddRoundKey stage (slave).
interface addroundkey_round_ctrl_if;
  import aes_pkg::*;

  aes_blk_t rk_data;
  logic     rk_valid;
  logic     rk_ready;

  modport master (output rk_data, output rk_valid, input rk_ready);
  modport slave  (input rk_data, input rk_valid, output rk_ready);
endinterface

// File: rtl/round_key_xor.sv
// AddRoundKey datapath: pick the round source (plaintext / MixColumns / ShiftRows) and XOR the key.
module round_key_xor
  import aes_pkg::*;
(
  input  ark_src_e i_sel,
  input  aes_blk_t i_pt,
  input  aes_blk_t i_mc,
  input  aes_blk_t i_sr,
  input  aes_blk_t i_rk,
  output aes_blk_t o_data
);
  aes_blk_t w_src;

  always_comb begin
    w_src = i_pt;
    case (i_sel)
      SRC_MC:  w_src = i_mc;
      SRC_SR:  w_src = i_sr;
      default: w_src = i_pt;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign o_data[l*VEC_W +: VEC_W] = w_src[l*VEC_W +: VEC_W] ^ i_rk[l*VEC_W +: VEC_W];
  end
endmodule

// File: rtl/addroundkey_round_ctrl.sv
// AES-128 round-state register and round controller; consumes NR+1 keys per block from a valid/ready stream.
module addroundkey_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  aes_blk_t                       pt_data,
  input  aes_blk_t                       mc_data,
  input  aes_blk_t                       sr_data,
  addroundkey_round_ctrl_if.slave        rk,
  output aes_blk_t                       state_q,
  output logic [3:0]                     round_q,
  output logic                           busy,
  output logic                           done
);
  ark_state_e r_fsm;
  aes_blk_t   r_pt, r_state_q, w_xor;
  logic [3:0] r_round, w_round_nxt;
  logic       r_rk_ready, r_busy, r_done;
  logic       w_hs, w_last;
  ark_src_e   w_sel;

  // rk_ready is a register, so the handshake never loops back combinationally into the key source.
  assign w_hs        = rk.rk_valid & r_rk_ready;
  assign w_round_nxt = r_round + 4'd1;
  assign w_last      = (w_round_nxt == 4'(NR));
  assign w_sel       = (r_fsm == LOAD) ? SRC_PT : (w_last ? SRC_SR : SRC_MC);

  round_key_xor u_xor (
    .i_sel  (w_sel),
    .i_pt   (r_pt),
    .i_mc   (mc_data),
    .i_sr   (sr_data),
    .i_rk   (rk.rk_data),
    .o_data (w_xor)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_pt       <= '0;
      r_state_q  <= '0;
      r_round    <= '0;
      r_rk_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: if (start) begin
          r_pt       <= pt_data;
          r_round    <= '0;
          r_rk_ready <= 1'b1;
          r_busy     <= 1'b1;
          r_fsm      <= LOAD;
        end
        LOAD: if (w_hs) begin
          r_state_q <= w_xor;
          r_fsm     <= ROUND;
        end
        ROUND: if (w_hs) begin
          r_state_q <= w_xor;
          r_round   <= w_round_nxt;
          // Final round drops ready in the same edge so key NR+1 is never offered a handshake.
          if (w_last) begin
            r_rk_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_fsm      <= DONE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign rk.rk_ready = r_rk_ready;
  assign state_q     = r_state_q;
  assign round_q     = r_round;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule

// File: tb/tb_addroundkey_round_ctrl.sv
// Closes the AES round loop around the DUT with behavioural SubBytes/ShiftRows/MixColumns and checks it every cycle.
module tb_addroundkey_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES_NR_128;
  localparam aes_blk_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_blk_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_blk_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam aes_blk_t LD_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_blk_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_blk_t PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_blk_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       clk, rst_n, start;
  aes_blk_t   pt_data, state_q, w_sr, w_mc;
  logic [3:0] round_q;
  logic       busy, done;

  addroundkey_round_ctrl_if rk_if ();

  addroundkey_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pt_data(pt_data),
    .mc_data(w_mc), .sr_data(w_sr), .rk(rk_if),
    .state_q(state_q), .round_q(round_q), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0]  x, p, s;
    logic [15:0] t;
    x = a; p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      x = gm(x, x);
      p = gm(p, x);
    end
    s = p ^ 8'h63;
    for (int n = 1; n < 5; n++) begin
      t = {p, p} << n;
      s = s ^ t[15:8];
    end
    return s;
  endfunction

  function automatic aes_blk_t sub_bytes(input aes_blk_t s);
    aes_blk_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
    return o;
  endfunction

  function automatic aes_blk_t shift_rows(input aes_blk_t s);
    aes_blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic aes_blk_t mix_cols(input aes_blk_t s);
    aes_blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic aes_blk_t aes_round(input aes_blk_t s, input logic last);
    aes_blk_t t;
    t = shift_rows(sub_bytes(s));
    return last ? t : mix_cols(t);
  endfunction

  assign w_sr = shift_rows(sub_bytes(state_q));
  assign w_mc = mix_cols(w_sr);

  aes_blk_t rks [0:NR];

  task automatic expand(input aes_blk_t key);
    logic [31:0] w [0:4*(NR+1)-1];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a block is "active" until NR+1 keys are taken, then one done cycle.
  logic     m_vld = 1'b0, m_act = 1'b0, m_done = 1'b0;
  int       m_keys = 0;
  logic [3:0] m_round = '0;
  aes_blk_t m_state = '0, m_pt = '0;
  int       hs_total = 0, stall_total = 0, kidx = 0;
  logic     stall_en = 1'b0;

  task automatic cycle();
    logic hs, r;
    r  = rst_n;
    hs = rst_n && rk_if.rk_valid && rk_if.rk_ready;
    if (hs) hs_total++;
    if (!r) begin
      m_vld = 1'b1; m_act = 1'b0; m_done = 1'b0; m_keys = 0;
      m_round = '0; m_state = '0; m_pt = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_pt = pt_data; m_round = '0; m_act = 1'b1; m_keys = 0;
      end
    end else if (rk_if.rk_valid) begin
      if (m_keys == 0) m_state = m_pt ^ rk_if.rk_data;
      else begin
        m_state = aes_round(m_state, m_keys == NR) ^ rk_if.rk_data;
        m_round = 4'(m_keys);
      end
      m_keys++;
      if (m_keys == NR + 1) begin
        m_act = 1'b0; m_done = 1'b1;
      end
    end else begin
      stall_total++;
    end
    @(posedge clk); #1;
    // Key source: one key per handshake, rewinds on reset and after the final key.
    if (!r) kidx = 0;
    else if (hs) kidx = (kidx == NR) ? 0 : kidx + 1;
    rk_if.rk_valid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    rk_if.rk_data  = rk_if.rk_valid ? rks[kidx] : {$urandom, $urandom, $urandom, $urandom};
    if (m_vld) begin
      chk("state_q",  state_q,           m_state);
      chk("round_q",  128'(round_q),     128'(m_round));
      chk("busy",     128'(busy),        128'(m_act));
      chk("rk_ready", 128'(rk_if.rk_ready), 128'(m_act));
      chk("done",     128'(done),        128'(m_done));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state_q"},  state_q,               128'h0);
    chk({tag, "_round_q"},  128'(round_q),         128'h0);
    chk({tag, "_busy"},     128'(busy),            128'h0);
    chk({tag, "_rk_ready"}, 128'(rk_if.rk_ready),  128'h0);
    chk({tag, "_done"},     128'(done),            128'h0);
  endtask

  task automatic run_block(input aes_blk_t pt, input aes_blk_t exp_ct, input logic pin_load,
                           input int start_rnd, input logic start_done, input int rst_rnd);
    int   n, hs0, st0;
    logic got, inj, pinned;
    hs0 = hs_total; st0 = stall_total;
    pt_data = pt; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("round_restart", 128'(round_q), 128'h0);
    n = 0; got = 1'b0; inj = 1'b0; pinned = 1'b0;
    while (n < 300 && !got) begin
      if (pin_load && m_keys == 1 && !pinned) begin
        chk("load_state", state_q, LD_B);
        pinned = 1'b1;
      end
      if (done) got = 1'b1;
      else begin
        if (rst_rnd >= 0 && round_q == 4'(rst_rnd)) begin
          rst_n = 1'b0;
          cycle();
          rst_n = 1'b1;
          chk_reset("abort");
          repeat (3) begin
            cycle();
            chk("abort_no_done", 128'(done), 128'h0);
          end
          return;
        end
        start = (start_rnd >= 0 && round_q == 4'(start_rnd) && !inj);
        if (start) inj = 1'b1;
        cycle();
        n++;
      end
    end
    start = 1'b0;
    chk("done_seen",  128'(got),             128'h1);
    chk("latency",    128'(n + 2),           128'(13 + stall_total - st0));
    chk("ciphertext", state_q,               exp_ct);
    chk("final_round", 128'(round_q),        128'(NR));
    chk("handshakes", 128'(hs_total - hs0),  128'(NR + 1));
    if (start_done) begin
      start = 1'b1; pt_data = ~pt;
    end
    cycle();
    start = 1'b0;
    if (start_done) begin
      repeat (3) begin
        chk("start_in_done_busy", 128'(busy), 128'h0);
        cycle();
      end
      chk("ct_hold", state_q, exp_ct);
    end
  endtask

  int hs_b2b;

  initial begin
    rst_n = 1'b0; start = 1'b0; pt_data = '0;
    rk_if.rk_valid = 1'b0; rk_if.rk_data = '0;
    expand(KEY_B);
    chk("rk1_lit",  rks[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("rk10_lit", rks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (2) cycle();
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) cycle();

    run_block(PT_B, CT_B, 1'b1, -1, 1'b0, -1);
    stall_en = 1'b1;
    run_block(PT_B, CT_B, 1'b1, -1, 1'b0, -1);
    stall_en = 1'b0;
    run_block(PT_B, CT_B, 1'b1, 4, 1'b1, -1);
    run_block(PT_B, CT_B, 1'b0, -1, 1'b0, 6);
    run_block(PT_B, CT_B, 1'b1, -1, 1'b0, -1);

    hs_b2b = hs_total;
    run_block(PT_B, CT_B, 1'b1, -1, 1'b0, -1);
    expand(KEY_C);
    run_block(PT_C, CT_C, 1'b0, -1, 1'b0, -1);
    chk("b2b_handshakes", 128'(hs_total - hs_b2b), 128'(2 * (NR + 1)));
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
